// File: rtl/rpn_token_sequencer.sv
// RPN token sequencer: turns a postfix token stream into stack-ALU commands,
// tracks stack depth for malformed expressions and returns the popped result.
module rpn_token_sequencer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned STACK_SIZE  = 64,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic                  tok_op,
  input  logic [DATA_WIDTH-1:0] tok_value,
  input  logic                  tok_last,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_input_data,
  input  logic [DATA_WIDTH-1:0] alu_output_data,
  input  logic                  alu_overflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_overflow,
  output logic                  res_error
);

  localparam int unsigned DEPTH_W = $clog2(STACK_SIZE + 1);
  localparam int unsigned WAIT_W  = $clog2(ALU_LATENCY + 1) + 1;
  localparam int unsigned PIPE_W  = ALU_LATENCY;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [PIPE_W-1:0] PIPE_MSB = PIPE_W'(1 << (PIPE_W - 1));

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_POP,
    ST_DRAIN,
    ST_RESULT
  } state_t;

  state_t              state;
  logic [DEPTH_W-1:0]  depth;
  logic                err;
  logic                ovf;
  logic [PIPE_W-1:0]   ovf_pipe;
  logic                popped;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                accept_c;
  logic                arith_c;
  logic                ovf_next_c;
  logic                ovf_later_c;
  logic [2:0]          tok_cmd_c;
  logic                tok_err_c;
  logic                err_after_c;
  logic [DEPTH_W-1:0]  depth_after_c;

  assign accept_c    = tok_valid && tok_ready;
  assign arith_c     = (alu_opcode == OP_ADD) || (alu_opcode == OP_MUL);
  // ovf_pipe MSB marks the cycle whose alu_overflow belongs to an earlier ADD/MUL
  assign ovf_next_c  = ovf | (ovf_pipe[PIPE_W-1] & alu_overflow);
  assign ovf_later_c = arith_c | (|(ovf_pipe & ~PIPE_MSB));
  assign err_after_c = err | tok_err_c;

  // Command and depth effect of the token currently offered
  always_comb begin
    tok_cmd_c     = OP_NOP;
    tok_err_c     = 1'b0;
    depth_after_c = depth;
    if (!err) begin
      if (tok_is_op) begin
        if (depth < DEPTH_W'(2)) begin
          tok_err_c = 1'b1;
        end else begin
          tok_cmd_c     = tok_op ? OP_MUL : OP_ADD;
          depth_after_c = depth - DEPTH_W'(1);
        end
      end else if (depth == DEPTH_W'(STACK_SIZE)) begin
        tok_err_c = 1'b1;
      end else begin
        tok_cmd_c     = OP_PUSH;
        depth_after_c = depth + DEPTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_ACCEPT;
      depth          <= '0;
      err            <= 1'b0;
      ovf            <= 1'b0;
      ovf_pipe       <= '0;
      popped         <= 1'b0;
      wait_cnt       <= '0;
      tok_ready      <= 1'b0;
      alu_opcode     <= OP_NOP;
      alu_input_data <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_overflow   <= 1'b0;
      res_error      <= 1'b0;
    end else begin
      alu_opcode <= OP_NOP;
      ovf_pipe   <= PIPE_W'({ovf_pipe, arith_c});
      ovf        <= ovf_next_c;

      case (state)
        ST_ACCEPT: begin
          tok_ready <= 1'b1;
          if (accept_c) begin
            alu_opcode <= tok_cmd_c;
            if (tok_cmd_c == OP_PUSH) begin
              alu_input_data <= tok_value;
            end
            depth <= depth_after_c;
            err   <= err_after_c;
            if (tok_last) begin
              tok_ready <= 1'b0;
              if (!err_after_c && depth_after_c == DEPTH_W'(1)) begin
                state  <= ST_POP;
                popped <= 1'b0;
              end else begin
                err      <= 1'b1;
                res_data <= '0;
                if (depth_after_c == '0) begin
                  state        <= ST_RESULT;
                  res_valid    <= 1'b1;
                  res_error    <= 1'b1;
                  res_overflow <= ovf_next_c;
                end else begin
                  state <= ST_DRAIN;
                end
              end
            end
          end
        end

        // Pop the single result, then wait for it to appear on the ALU output
        ST_POP: begin
          if (!popped) begin
            alu_opcode <= OP_POP;
            depth      <= '0;
            popped     <= 1'b1;
            wait_cnt   <= '0;
          end else if (wait_cnt == WAIT_W'(ALU_LATENCY)) begin
            res_data     <= alu_output_data;
            res_overflow <= ovf_next_c;
            res_error    <= err;
            res_valid    <= 1'b1;
            state        <= ST_RESULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        // Empty the ALU stack so the next expression starts clean
        ST_DRAIN: begin
          if (depth != '0) begin
            alu_opcode <= OP_POP;
            depth      <= depth - DEPTH_W'(1);
          end else if (!ovf_later_c) begin
            res_data     <= '0;
            res_overflow <= ovf_next_c;
            res_error    <= 1'b1;
            res_valid    <= 1'b1;
            state        <= ST_RESULT;
          end
        end

        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            tok_ready <= 1'b1;
            state     <= ST_ACCEPT;
          end
        end

        default: begin
          state <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_token_sequencer.sv
// Directed bench for rpn_token_sequencer with a behavioural stack-ALU model.
module tb_rpn_token_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned SS = 64;
  localparam int unsigned AL = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_is_op = 1'b0;
  logic          tok_op = 1'b0;
  logic [DW-1:0] tok_value = '0;
  logic          tok_last = 1'b0;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_input_data;
  logic [DW-1:0] alu_output_data;
  logic          alu_overflow;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_overflow;
  logic          res_error;

  int checks = 0;
  int errors = 0;

  rpn_token_sequencer #(
    .DATA_WIDTH (DW),
    .STACK_SIZE (SS),
    .ALU_LATENCY(AL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tok_valid      (tok_valid),
    .tok_ready      (tok_ready),
    .tok_is_op      (tok_is_op),
    .tok_op         (tok_op),
    .tok_value      (tok_value),
    .tok_last       (tok_last),
    .alu_opcode     (alu_opcode),
    .alu_input_data (alu_input_data),
    .alu_output_data(alu_output_data),
    .alu_overflow   (alu_overflow),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_overflow   (res_overflow),
    .res_error      (res_error)
  );

  always #5 clk = ~clk;

  // Stack ALU model: one-cycle command latency, per-command overflow flag
  logic [DW-1:0] stk [0:127];
  int            sp;
  logic [DW-1:0] opa, opb;
  logic [16:0]   add_r;
  logic [31:0]   mul_r;

  always_comb begin
    opa = (sp >= 2) ? stk[7'(sp - 2)] : '0;
    opb = (sp >= 1) ? stk[7'(sp - 1)] : '0;
  end
  assign add_r = {1'b0, opa} + {1'b0, opb};
  assign mul_r = {16'b0, opa} * {16'b0, opb};

  always @(posedge clk) begin
    case (alu_opcode)
      3'b110:  stk[7'(sp)]     <= alu_input_data;
      3'b100:  stk[7'(sp - 2)] <= add_r[15:0];
      3'b101:  stk[7'(sp - 2)] <= mul_r[15:0];
      default: ;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp              <= 0;
      alu_output_data <= '0;
      alu_overflow    <= 1'b0;
    end else begin
      case (alu_opcode)
        3'b110: begin sp <= sp + 1; alu_output_data <= alu_input_data; alu_overflow <= 1'b0; end
        3'b100: begin sp <= sp - 1; alu_output_data <= add_r[15:0]; alu_overflow <= add_r[16]; end
        3'b101: begin sp <= sp - 1; alu_output_data <= mul_r[15:0]; alu_overflow <= |mul_r[31:16]; end
        3'b111: begin sp <= sp - 1; alu_output_data <= opb; alu_overflow <= 1'b0; end
        default: ;
      endcase
    end
  end

  logic [2:0] op_log [$];
  always @(posedge clk) begin
    if (rst_n && alu_opcode != 3'b000) op_log.push_back(alu_opcode);
  end

  function automatic int count_ops(input int from, input logic [2:0] op);
    int n = 0;
    for (int k = from; k < op_log.size(); k++) if (op_log[k] == op) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic is_op, input logic op, input logic [DW-1:0] val, input logic last);
    int n = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_op    = op;
    tok_value = val;
    tok_last  = last;
    while (!tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) check("tok_ready_timeout", 32'(tok_ready), 32'd1);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    tok_last  = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] v, input logic last);
    send(1'b0, 1'b0, v, last);
  endtask

  task automatic oper(input logic op, input logic last);
    send(1'b1, op, '0, last);
  endtask

  task automatic get_result(input string tag, input logic [DW-1:0] d, input logic o,
                            input logic e, input int lat);
    int n = 0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (res_valid) break;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (lat >= 0) check({tag, "_latency"}, 32'(n - 1), 32'(lat));
    check({tag, "_data"}, 32'(res_data), 32'(d));
    check({tag, "_ovf"}, 32'(res_overflow), 32'(o));
    check({tag, "_err"}, 32'(res_error), 32'(e));
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_released"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int start;

    repeat (3) @(negedge clk);
    check("rst_tok_ready", 32'(tok_ready), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tok_ready", 32'(tok_ready), 32'd1);

    // 3 * 2
    start = op_log.size();
    push(16'h0003, 1'b0);
    push(16'h0002, 1'b0);
    oper(1'b1, 1'b1);
    get_result("mul", 16'h0006, 1'b0, 1'b0, 3);
    check("mul_cmd_count", 32'(op_log.size() - start), 32'd4);
    check("mul_cmd0", 32'(op_log[start]), 32'h6);
    check("mul_cmd1", 32'(op_log[start + 1]), 32'h6);
    check("mul_cmd2", 32'(op_log[start + 2]), 32'h5);
    check("mul_cmd3", 32'(op_log[start + 3]), 32'h7);

    // 0xFFFF + 2 wraps to 1 with overflow
    push(16'hFFFF, 1'b0);
    push(16'h0002, 1'b0);
    oper(1'b0, 1'b1);
    get_result("addovf", 16'h0001, 1'b1, 1'b0, 3);

    // operator with one operand: ADD suppressed, one drain POP
    start = op_log.size();
    push(16'h0005, 1'b0);
    oper(1'b0, 1'b1);
    get_result("underflow", 16'h0000, 1'b0, 1'b1, -1);
    check("underflow_cmds", 32'(op_log.size() - start), 32'd2);
    check("underflow_adds", 32'(count_ops(start, 3'b100)), 32'd0);
    check("underflow_pops", 32'(count_ops(start, 3'b111)), 32'd1);

    // leftover operands: two drain POPs, then a clean expression
    start = op_log.size();
    push(16'd1, 1'b0);
    push(16'd2, 1'b0);
    push(16'd3, 1'b0);
    oper(1'b0, 1'b1);
    get_result("leftover", 16'h0000, 1'b0, 1'b1, -1);
    check("leftover_pops", 32'(count_ops(start, 3'b111)), 32'd2);
    push(16'd4, 1'b0);
    push(16'd5, 1'b0);
    oper(1'b1, 1'b1);
    get_result("after_leftover", 16'h0014, 1'b0, 1'b0, 3);

    // result backpressure
    push(16'd7, 1'b0);
    push(16'd8, 1'b0);
    oper(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data", 32'(res_data), 32'h000F);
      check("bp_tok_ready", 32'(tok_ready), 32'd0);
      check("bp_opcode", 32'(alu_opcode), 32'd0);
      @(negedge clk);
    end
    get_result("bp", 16'h000F, 1'b0, 1'b0, -1);

    // one push beyond the stack size
    start = op_log.size();
    for (int i = 0; i <= SS; i++) push(16'(i + 1), (i == SS));
    get_result("full", 16'h0000, 1'b0, 1'b1, -1);
    check("full_pushes", 32'(count_ops(start, 3'b110)), 32'(SS));
    check("full_pops", 32'(count_ops(start, 3'b111)), 32'(SS));
    push(16'd9, 1'b0);
    push(16'd3, 1'b0);
    oper(1'b0, 1'b1);
    get_result("after_full", 16'h000C, 1'b0, 1'b0, 3);

    // asynchronous reset mid-expression
    push(16'h0011, 1'b0);
    push(16'h0022, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_opcode", 32'(alu_opcode), 32'd0);
    check("mid_rst_data", 32'(alu_input_data), 32'd0);
    check("mid_rst_tok_ready", 32'(tok_ready), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_res_flags", 32'({res_overflow, res_error}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_release_ready", 32'(tok_ready), 32'd1);
    push(16'd6, 1'b0);
    push(16'd7, 1'b0);
    oper(1'b1, 1'b1);
    get_result("after_rst", 16'h002A, 1'b0, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpn_token_sequencer.md
Name: rpn_token_sequencer

Overview:
- Upstream feeder for the stack-based ALU; accepts a postfix (RPN) token stream over a valid/ready handshake.
- Turns each token into one ALU command (PUSH, ADD, MUL) and tracks stack depth to detect malformed expressions.
- At end of expression, pops the result and returns it with sticky overflow and error flags.
- On error, drains the ALU stack with POPs so the next expression starts on an empty stack.

Parameters:
- DATA_WIDTH, 16, operand/result width; must match the ALU.
- STACK_SIZE, 64, ALU stack depth; the sequencer rejects pushes beyond this.
- ALU_LATENCY, 1, cycles from a command on alu_opcode to its effect on alu_output_data/alu_overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- tok_valid  in  1  token offered.
- tok_ready  out  1  token accepted when tok_valid && tok_ready.
- tok_is_op  in  1  1 = operator, 0 = operand.
- tok_op  in  1  operator select: 0 = ADD, 1 = MUL (ignored for operands).
- tok_value  in  DATA_WIDTH  operand value.
- tok_last  in  1  final token of the expression.
- alu_opcode  out  3  ALU command, registered.
- alu_input_data  out  DATA_WIDTH  ALU push data, registered.
- alu_output_data  in  DATA_WIDTH  ALU result.
- alu_overflow  in  1  ALU overflow flag.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_data  out  DATA_WIDTH  popped result; 0 on error.
- res_overflow  out  1  any ADD/MUL in the expression overflowed.
- res_error  out  1  malformed expression or stack full.

Behaviour:
- Opcode encoding (fixed):
  - NOP = 3'b000, ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111.
  - alu_opcode = NOP whenever no command is issued.
- Reset values (async on rst_n low):
  - state = ACCEPT; depth = 0.
  - alu_opcode = NOP; alu_input_data = 0.
  - tok_ready = 0 during reset, 1 in the first cycle after reset.
  - res_valid, res_data, res_overflow, res_error = 0; all sticky flags cleared.
- Mid-expression reset: the ALU has no reset, so its stack contents are undefined; the system must reset both blocks together.
- depth width is clog2(STACK_SIZE+1).
- State ACCEPT (tok_ready = 1, at most one token per cycle):
  - Accepted token drives alu_opcode/alu_input_data from the next edge, held for exactly one cycle.
  - Operand: if depth == STACK_SIZE, set err and issue NOP; else issue PUSH with tok_value, depth += 1.
  - Operator: if depth < 2, set err and issue NOP; else issue ADD/MUL, depth -= 1.
  - Once err is set, later tokens are accepted and discarded (NOP) until tok_last.
  - tok_last accepted: if !err && depth after the token == 1, go to POP. Otherwise set err and go to DRAIN; go to RESULT directly if depth == 0.
- Overflow capture: alu_overflow is sampled ALU_LATENCY cycles after each ADD/MUL issue and ORed into a sticky ovf. Samples due after the expression ends are still taken before RESULT is entered.
- State POP (tok_ready = 0):
  - Issue POP for one cycle, depth = 0.
  - Wait ALU_LATENCY cycles, capture alu_output_data into res_data, go to RESULT.
- State DRAIN (tok_ready = 0):
  - Issue POP on consecutive cycles, decrementing depth, until depth == 0.
  - res_data = 0, then go to RESULT.
- State RESULT (tok_ready = 0):
  - res_valid = 1; res_data, res_overflow, res_error held stable until res_ready.
  - On handshake: res_valid = 0, clear err/ovf, return to ACCEPT on the next cycle.
- Latency (ALU_LATENCY = 1, single-token-per-cycle input): res_valid rises 3 cycles after the tok_last handshake edge (issue, POP, capture).
- tok_valid while tok_ready = 0: the token is held by upstream, never dropped.

Test Plan:
- Basic multiply: push 0x0003, push 0x0002, MUL (last) → alu_opcode sequence PUSH, PUSH, MUL, POP; res_data = 0x0006, res_overflow = 0, res_error = 0.
- Add overflow: 0xFFFF, 0x0002, ADD (last) → res_data = 0x0001, res_overflow = 1, res_error = 0.
- Underflow: 0x0005, ADD (last) → ADD suppressed (NOP); one DRAIN POP; res_error = 1, res_data = 0.
- Leftover operands: 1, 2, 3, ADD (last) → final depth 2; exactly two POPs issued; res_error = 1. A following expression 4, 5, MUL (last) gives 0x0014 with no error.
- Backpressure: hold res_ready = 0 for 5 cycles → res_valid/res_data stable, tok_ready = 0, alu_opcode = NOP; result released on res_ready = 1.
- Stack full and reset: STACK_SIZE + 1 pushes → res_error = 1 and STACK_SIZE DRAIN POPs. Separately, rst_n low mid-expression → all outputs return to reset values immediately (asynchronously) and tok_ready = 1 after release.
